mmcm_phase_sweep: RTL
=====================

// Module: mmcm_phase_sweep
// PURPOSE
//  Initiator side of the MMCM absolute-phase interface (ps_we/ps_din/ps_ready/ps_dout): sweeps phase
//  from a start value in fixed steps, waits for each shift to complete plus a settle time, requests one
//  pass/fail measurement per step and tracks the longest contiguous passing window. Sits in the
//  psclk domain between the calibration sequencer and the phase-counter MMCM wrapper.
// PARAMETERS
//  PHASE_WIDTH   8    width of phase values (matches the MMCM wrapper's phase counter)
//  STEPS_WIDTH   8    width of step-count input and window-length output
//  SETTLE_CYCLES 16   psclk cycles waited after ps_ready returns high before measurement (>=1)
// PORTS
//  psclk       in  1            single clock; all logic on rising edge
//  rst         in  1            asynchronous reset, active high
//  start       in  1            1-cycle pulse; begins sweep when idle, ignored while busy
//  start_phase in  PHASE_WIDTH  first phase value (2's complement)
//  step        in  PHASE_WIDTH  phase increment per step (2's complement, may be negative)
//  num_steps   in  STEPS_WIDTH  number of phases tested; 0 = no sweep
//  busy        out 1            high from accepted start to done
//  done        out 1            1-cycle pulse at sweep end
//  ps_we       out 1            phase write strobe to MMCM wrapper
//  ps_din      out PHASE_WIDTH  phase value written
//  ps_ready    in  1            wrapper ready (locked, no shift in progress)
//  meas_req    out 1            measurement request, held until meas_ack
//  meas_ack    in  1            measurement complete (sampled with meas_pass)
//  meas_pass   in  1            1 = current phase passed
//  best_start  out PHASE_WIDTH  first phase of longest passing window
//  best_end    out PHASE_WIDTH  last phase of longest passing window
//  best_len    out STEPS_WIDTH  length of longest window (0 = none passed)
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE; rst mid-sweep aborts immediately, no further ps_we/meas_req.
//  Inputs start_phase/step/num_steps latched on accepted start; later changes ignored until next start.
//  States: IDLE -> (start, num_steps!=0) SET; (start, num_steps==0) DONE with best_* cleared.
//   SET: wait ps_ready=1, then ps_we=1 for exactly one cycle with ps_din=cur_phase -> BLANK.
//   BLANK: one cycle, ps_ready ignored (wrapper drops it one cycle after write) -> WAIT_RDY.
//   WAIT_RDY: wait ps_ready=1 -> SETTLE (counter loaded SETTLE_CYCLES-1, exits at 0).
//   MEAS: meas_req=1 until cycle with meas_ack=1; meas_pass sampled that cycle; meas_req low next cycle.
//   NEXT: update run tracking; remaining--; cur_phase += step (mod 2^PHASE_WIDTH, wraps);
//    remaining==0 -> CENTER/DONE else SET.
//   DONE: done=1 one cycle, busy=0 from next cycle -> IDLE.
//  busy=1 in every state except IDLE (and deasserts the cycle after done).
//  Run tracking: pass -> run_len++, run_start=cur_phase if run_len was 0; fail -> run_len=0.
//   After a pass, if run_len_new > best_len (strict; earliest window wins ties):
//   best_start=run_start, best_end=cur_phase, best_len=run_len_new. No wrap-around joining of runs.
//  best_* cleared on accepted start, hold last values after done until next start.
//  ps_we never asserted while ps_ready=0; meas_req never asserted during a phase change.
// CONFIGURATION
//  MMCM_PHASE_SWEEP_CENTER_EN defined: after last step, if best_len!=0 go to CENTER: write
//   center = best_start + ((best_end-best_start) mod 2^PHASE_WIDTH)>>1 (logical shift) using the
//   SET/BLANK/WAIT_RDY handshake, then DONE (done only after ps_ready returns). best_len==0: write
//   start_phase back instead. Not defined: no CENTER state; MMCM left at last swept phase.
// TESTING
//  start_phase=0x10,step=1,num_steps=8, pass on 0x12..0x15 -> 8 ps_we 0x10..0x17, best 0x12/0x15/4.
//  step=0xFE(-2),start_phase=0x02,num_steps=4 -> ps_din 0x02,0x00,0xFE,0xFC (wrap), one meas each.
//  Runs pass 2,fail,pass 2 -> best_len=2, best_start = first run (tie rule).
//  ps_ready held low 50 cycles before first write -> ps_we waits; meas_req only SETTLE_CYCLES after ready.
//  num_steps=0 -> done 1 cycle after start, no ps_we/meas_req, best_len=0; start while busy ignored.
//  rst during MEAS -> all outputs 0 next edge; CENTER_EN: pass 0x12..0x15 -> final ps_din=0x13.

Source files
------------

// File: rtl/mmcm_phase_sweep_if.sv
// Bundles the sweep controller's request, MMCM phase-write and measurement signals.
// master = the sweep controller, slave = sequencer / MMCM wrapper / measurement side.
interface mmcm_phase_sweep_if #(
    parameter int PHASE_WIDTH = 8,
    parameter int STEPS_WIDTH = 8
);
    logic                   start;
    logic [PHASE_WIDTH-1:0] start_phase;
    logic [PHASE_WIDTH-1:0] step;
    logic [STEPS_WIDTH-1:0] num_steps;
    logic                   busy;
    logic                   done;
    logic                   ps_we;
    logic [PHASE_WIDTH-1:0] ps_din;
    logic                   ps_ready;
    logic                   meas_req;
    logic                   meas_ack;
    logic                   meas_pass;
    logic [PHASE_WIDTH-1:0] best_start;
    logic [PHASE_WIDTH-1:0] best_end;
    logic [STEPS_WIDTH-1:0] best_len;

    modport master (
        input  start, start_phase, step, num_steps, ps_ready, meas_ack, meas_pass,
        output busy, done, ps_we, ps_din, meas_req, best_start, best_end, best_len
    );

    modport slave (
        output start, start_phase, step, num_steps, ps_ready, meas_ack, meas_pass,
        input  busy, done, ps_we, ps_din, meas_req, best_start, best_end, best_len
    );
endinterface

// File: rtl/mmcm_phase_sweep.sv
// MMCM phase sweep initiator: steps the absolute phase, measures each step and keeps the longest
// passing window. Define MMCM_PHASE_SWEEP_CENTER_EN to park the MMCM at the window centre afterwards.
module mmcm_phase_sweep #(
    parameter int PHASE_WIDTH   = 8,
    parameter int STEPS_WIDTH   = 8,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic                  psclk,
    input  logic                  rst,
    mmcm_phase_sweep_if.master    bus
);

    // state    | meaning
    // IDLE     | waiting for start
    // SET      | waiting for ps_ready, then one-cycle ps_we of cur_phase
    // BLANK    | wrapper still shows the pre-write ps_ready, ignore it
    // WAIT_RDY | waiting for the phase shift to finish
    // SETTLE   | post-shift settle countdown
    // MEAS     | meas_req held until meas_ack
    // NEXT     | run tracking, advance phase, decide end of sweep
    // CENTER   | load window centre (or start phase) for the final write
    // DONE     | one-cycle done pulse
    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_SET      = 4'd1;
    localparam logic [3:0] S_BLANK    = 4'd2;
    localparam logic [3:0] S_WAIT_RDY = 4'd3;
    localparam logic [3:0] S_SETTLE   = 4'd4;
    localparam logic [3:0] S_MEAS     = 4'd5;
    localparam logic [3:0] S_NEXT     = 4'd6;
    localparam logic [3:0] S_DONE     = 4'd7;
`ifdef MMCM_PHASE_SWEEP_CENTER_EN
    localparam logic [3:0] S_CENTER   = 4'd8;
`endif

    localparam int              CNT_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    logic [3:0]             state;
    logic [PHASE_WIDTH-1:0] cur_phase;
    logic [PHASE_WIDTH-1:0] step_r;
    logic [STEPS_WIDTH-1:0] remaining;
    logic [CNT_W-1:0]       settle_cnt;
    logic                   pass_r;
    logic [STEPS_WIDTH-1:0] run_len;
    logic [PHASE_WIDTH-1:0] run_start;
    logic [PHASE_WIDTH-1:0] best_start_r;
    logic [PHASE_WIDTH-1:0] best_end_r;
    logic [STEPS_WIDTH-1:0] best_len_r;

    logic [STEPS_WIDTH-1:0] run_len_inc;
    logic [PHASE_WIDTH-1:0] run_start_new;

    assign run_len_inc   = run_len + 1'b1;
    assign run_start_new = (run_len == '0) ? cur_phase : run_start;

`ifdef MMCM_PHASE_SWEEP_CENTER_EN
    logic                   centering;
    logic [PHASE_WIDTH-1:0] start_phase_r;
    logic [PHASE_WIDTH-1:0] span;
    logic [PHASE_WIDTH-1:0] center;

    // span is taken modulo 2^PHASE_WIDTH so a window that crosses the wrap point still centres correctly
    assign span   = best_end_r - best_start_r;
    assign center = best_start_r + (span >> 1);
`endif

    always_ff @(posedge psclk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            cur_phase    <= '0;
            step_r       <= '0;
            remaining    <= '0;
            settle_cnt   <= '0;
            pass_r       <= 1'b0;
            run_len      <= '0;
            run_start    <= '0;
            best_start_r <= '0;
            best_end_r   <= '0;
            best_len_r   <= '0;
`ifdef MMCM_PHASE_SWEEP_CENTER_EN
            centering     <= 1'b0;
            start_phase_r <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        cur_phase    <= bus.start_phase;
                        step_r       <= bus.step;
                        remaining    <= bus.num_steps;
                        run_len      <= '0;
                        run_start    <= '0;
                        best_start_r <= '0;
                        best_end_r   <= '0;
                        best_len_r   <= '0;
`ifdef MMCM_PHASE_SWEEP_CENTER_EN
                        centering     <= 1'b0;
                        start_phase_r <= bus.start_phase;
`endif
                        state <= (bus.num_steps == '0) ? S_DONE : S_SET;
                    end
                end
                S_SET: begin
                    if (bus.ps_ready) state <= S_BLANK;
                end
                S_BLANK: state <= S_WAIT_RDY;
                S_WAIT_RDY: begin
                    if (bus.ps_ready) begin
`ifdef MMCM_PHASE_SWEEP_CENTER_EN
                        if (centering) begin
                            state <= S_DONE;
                        end else begin
                            settle_cnt <= SETTLE_LOAD;
                            state      <= S_SETTLE;
                        end
`else
                        settle_cnt <= SETTLE_LOAD;
                        state      <= S_SETTLE;
`endif
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt == '0) state <= S_MEAS;
                    else settle_cnt <= settle_cnt - 1'b1;
                end
                S_MEAS: begin
                    if (bus.meas_ack) begin
                        pass_r <= bus.meas_pass;
                        state  <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (pass_r) begin
                        run_len   <= run_len_inc;
                        run_start <= run_start_new;
                        // strict compare keeps the earliest window on a tie
                        if (run_len_inc > best_len_r) begin
                            best_start_r <= run_start_new;
                            best_end_r   <= cur_phase;
                            best_len_r   <= run_len_inc;
                        end
                    end else begin
                        run_len <= '0;
                    end
                    remaining <= remaining - 1'b1;
                    cur_phase <= cur_phase + step_r;
                    if (remaining == STEPS_WIDTH'(1)) begin
`ifdef MMCM_PHASE_SWEEP_CENTER_EN
                        state <= S_CENTER;
`else
                        state <= S_DONE;
`endif
                    end else begin
                        state <= S_SET;
                    end
                end
`ifdef MMCM_PHASE_SWEEP_CENTER_EN
                S_CENTER: begin
                    cur_phase <= (best_len_r != '0) ? center : start_phase_r;
                    centering <= 1'b1;
                    state     <= S_SET;
                end
`endif
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // ps_we is gated by ps_ready combinationally so a write can never be issued into a busy wrapper
    assign bus.ps_we      = (state == S_SET) && bus.ps_ready;
    assign bus.ps_din     = cur_phase;
    assign bus.meas_req   = (state == S_MEAS);
    assign bus.busy       = (state != S_IDLE);
    assign bus.done       = (state == S_DONE);
    assign bus.best_start = best_start_r;
    assign bus.best_end   = best_end_r;
    assign bus.best_len   = best_len_r;

endmodule
